washing_machine_sequencer: RTL and testbench

Parametrised, clocked wash-cycle sequencer with internal phase timers, a configurable rinse count, door-open pause/resume, abort-with-drain and fill-timeout fault detection. It sits between the front-panel/sensor inputs and the actuator drivers (fill valve, agitator, motor, pump, spin speed, door lock). External phase timers are not used.

---
 rtl/washing_machine_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_washing_machine_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/washing_machine_sequencer.sv
// Wash-cycle sequencer: fill/wash/drain passes, spin, door pause, abort drain, fill fault.
// Define WM_PREWASH_EN to add a prewash pass (cyc=0) ahead of the main wash.
module washing_machine_sequencer #(
  parameter int unsigned TW           = 16,
  parameter int unsigned T_FILL       = 100,
  parameter int unsigned T_WASH       = 400,
  parameter int unsigned T_RINSE      = 200,
  parameter int unsigned T_DRAIN      = 100,
  parameter int unsigned T_SPIN       = 300,
  parameter int unsigned RINSE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       door_open,
  input  logic       abort,
  input  logic       water_full,
  output logic       water_fill,
  output logic       agitator,
  output logic       motor,
  output logic       pump,
  output logic       spin_hi,
  output logic       door_lock,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [3:0] state,
  output logic [2:0] cyc
);

  localparam int unsigned CW = 3;
  localparam logic [CW-1:0] LAST_CYC = CW'(RINSE_CYCLES + 1);
`ifdef WM_PREWASH_EN
  localparam logic [CW-1:0] FIRST_CYC = CW'(0);
`else
  localparam logic [CW-1:0] FIRST_CYC = CW'(1);
`endif

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FILL   = 4'd1,
    S_WASH   = 4'd2,
    S_DRAIN  = 4'd3,
    S_SPIN   = 4'd4,
    S_PAUSE  = 4'd5,
    S_ADRAIN = 4'd6,
    S_DONE   = 4'd7,
    S_FAULT  = 4'd8
  } state_t;

  state_t          st_r, st_nxt, ret_r, ret_nxt;
  logic [TW-1:0]   timer_r, timer_nxt, last_c;
  logic [CW-1:0]   cyc_r, cyc_nxt;
  logic            expired_c;

  // Final timer value of the current timed state
  always_comb begin
    last_c = '0;
    case (st_r)
      S_FILL:           last_c = TW'(T_FILL - 1);
      S_WASH:           last_c = (cyc_r == CW'(1)) ? TW'(T_WASH - 1) : TW'(T_RINSE - 1);
      S_DRAIN, S_ADRAIN: last_c = TW'(T_DRAIN - 1);
      S_SPIN:           last_c = TW'(T_SPIN - 1);
      default:          last_c = '0;
    endcase
  end

  assign expired_c = (timer_r >= last_c);

  // Next state, return state, pass index and timer
  always_comb begin
    st_nxt    = st_r;
    ret_nxt   = ret_r;
    cyc_nxt   = cyc_r;
    timer_nxt = timer_r + TW'(1);
    case (st_r)
      S_IDLE: begin
        timer_nxt = '0;
        if (start && !door_open) begin
          st_nxt  = S_FILL;
          cyc_nxt = FIRST_CYC;
        end
      end
      S_FILL, S_WASH, S_DRAIN, S_SPIN: begin
        if (abort) begin
          st_nxt    = S_ADRAIN;
          timer_nxt = '0;
        end else if (door_open) begin
          // Held timer stays at its last value on expiry so resume exits at once
          st_nxt  = S_PAUSE;
          ret_nxt = st_r;
          if (expired_c) timer_nxt = timer_r;
        end else if (st_r == S_FILL && water_full) begin
          st_nxt    = S_WASH;
          timer_nxt = '0;
        end else if (expired_c) begin
          timer_nxt = '0;
          case (st_r)
            S_FILL:  st_nxt = S_FAULT;
            S_WASH:  st_nxt = S_DRAIN;
            S_DRAIN: begin
              if (cyc_r < LAST_CYC) begin
                st_nxt  = S_FILL;
                cyc_nxt = cyc_r + CW'(1);
              end else begin
                st_nxt = S_SPIN;
              end
            end
            default: st_nxt = S_DONE;
          endcase
        end
      end
      S_PAUSE: begin
        timer_nxt = timer_r;
        if (abort) begin
          st_nxt    = S_ADRAIN;
          timer_nxt = '0;
        end else if (!door_open && start) begin
          st_nxt = ret_r;
        end
      end
      S_ADRAIN: begin
        if (expired_c) begin
          st_nxt    = S_IDLE;
          timer_nxt = '0;
          cyc_nxt   = '0;
        end
      end
      S_DONE: begin
        st_nxt    = S_IDLE;
        timer_nxt = '0;
        cyc_nxt   = '0;
      end
      S_FAULT: begin
        timer_nxt = '0;
        if (abort) begin
          st_nxt  = S_IDLE;
          cyc_nxt = '0;
        end
      end
      default: begin
        st_nxt    = S_IDLE;
        timer_nxt = '0;
        cyc_nxt   = '0;
      end
    endcase
  end

  // State register with outputs registered from the next-state decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_r       <= S_IDLE;
      ret_r      <= S_IDLE;
      timer_r    <= '0;
      cyc_r      <= '0;
      water_fill <= 1'b0;
      agitator   <= 1'b0;
      motor      <= 1'b0;
      pump       <= 1'b0;
      spin_hi    <= 1'b0;
      door_lock  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      st_r       <= st_nxt;
      ret_r      <= ret_nxt;
      timer_r    <= timer_nxt;
      cyc_r      <= cyc_nxt;
      water_fill <= (st_nxt == S_FILL);
      agitator   <= (st_nxt == S_WASH);
      motor      <= (st_nxt == S_WASH) || (st_nxt == S_SPIN);
      pump       <= (st_nxt == S_DRAIN) || (st_nxt == S_ADRAIN);
      spin_hi    <= (st_nxt == S_SPIN);
      door_lock  <= (st_nxt inside {S_FILL, S_WASH, S_DRAIN, S_SPIN, S_ADRAIN});
      busy       <= !(st_nxt inside {S_IDLE, S_FAULT});
      done       <= (st_nxt == S_DONE);
      fault      <= (st_nxt == S_FAULT);
    end
  end

  assign state = st_r;
  assign cyc   = cyc_r;

endmodule

// File: tb/tb_washing_machine_sequencer.sv
// Self-checking bench for washing_machine_sequencer: per-cycle vector table with a scoreboard queue.
module tb_washing_machine_sequencer;

  localparam logic [3:0] IDLE = 4'd0, FILL = 4'd1, WASH = 4'd2, DRAIN = 4'd3, SPIN = 4'd4;
  localparam logic [3:0] PAUSE = 4'd5, ADRAIN = 4'd6, DONE = 4'd7, FAULT = 4'd8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, door_open = 1'b0, abort = 1'b0, water_full = 1'b0;
  logic       water_fill, agitator, motor, pump, spin_hi, door_lock, busy, done, fault;
  logic [3:0] state;
  logic [2:0] cyc;

  typedef struct {
    logic       start;
    logic       door;
    logic       abort;
    logic       wf;
    int         reps;
    logic [3:0] st;
    logic [2:0] cyc;
  } vec_t;

  typedef struct {
    logic [3:0] st;
    logic [2:0] cyc;
    logic [8:0] outs;
  } exp_t;

  vec_t table_q[$];
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  washing_machine_sequencer #(
    .TW(16), .T_FILL(8), .T_WASH(10), .T_RINSE(6), .T_DRAIN(4), .T_SPIN(5), .RINSE_CYCLES(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .door_open(door_open), .abort(abort),
    .water_full(water_full), .water_fill(water_fill), .agitator(agitator), .motor(motor),
    .pump(pump), .spin_hi(spin_hi), .door_lock(door_lock), .busy(busy), .done(done),
    .fault(fault), .state(state), .cyc(cyc)
  );

  always #5 clk = ~clk;

  // {water_fill, agitator, motor, pump, spin_hi, door_lock, busy, done, fault}
  function automatic logic [8:0] decode(input logic [3:0] s);
    case (s)
      FILL:    return 9'b100001100;
      WASH:    return 9'b011001100;
      DRAIN:   return 9'b000101100;
      SPIN:    return 9'b001011100;
      PAUSE:   return 9'b000000100;
      ADRAIN:  return 9'b000101100;
      DONE:    return 9'b000000110;
      FAULT:   return 9'b000000001;
      default: return 9'b000000000;
    endcase
  endfunction

  function automatic void add(input logic s, input logic d, input logic a, input logic w,
                              input int n, input logic [3:0] st, input logic [2:0] c);
    vec_t v;
    v = '{s, d, a, w, n, st, c};
    table_q.push_back(v);
  endfunction

  task automatic check_now(input string name, input exp_t e);
    logic [8:0] got;
    got = {water_fill, agitator, motor, pump, spin_hi, door_lock, busy, done, fault};
    checks++;
    if (state !== e.st || cyc !== e.cyc || got !== e.outs) begin
      errors++;
      $display("FAIL %s: got state=%0d cyc=%0d outs=%b, expected state=%0d cyc=%0d outs=%b",
               name, state, cyc, got, e.st, e.cyc, e.outs);
    end
  endtask

  task automatic step(input vec_t v);
    exp_t e;
    start      = v.start;
    door_open  = v.door;
    abort      = v.abort;
    water_full = v.wf;
    sb_q.push_back('{v.st, v.cyc, decode(v.st)});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    step_no++;
    check_now($sformatf("step %0d", step_no), e);
  endtask

  initial begin
    int   n;
    vec_t v;
    logic [2:0] first_cyc;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_now("reset", '{IDLE, 3'd0, 9'd0});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

`ifdef WM_PREWASH_EN
    first_cyc = 3'd0;
    // Prewash, main wash, one rinse, spin
    add(1,0,0,0,1,FILL,0);  add(0,0,0,0,2,FILL,0);  add(0,0,0,1,1,WASH,0);
    add(0,0,0,0,5,WASH,0);  add(0,0,0,0,1,DRAIN,0); add(0,0,0,0,3,DRAIN,0);
    add(0,0,0,0,1,FILL,1);  add(0,0,0,0,2,FILL,1);  add(0,0,0,1,1,WASH,1);
    add(0,0,0,0,9,WASH,1);  add(0,0,0,0,1,DRAIN,1); add(0,0,0,0,3,DRAIN,1);
    add(0,0,0,0,1,FILL,2);  add(0,0,0,0,2,FILL,2);  add(0,0,0,1,1,WASH,2);
    add(0,0,0,0,5,WASH,2);  add(0,0,0,0,1,DRAIN,2); add(0,0,0,0,3,DRAIN,2);
    add(0,0,0,0,1,SPIN,2);  add(0,0,0,0,4,SPIN,2);  add(0,0,0,0,1,DONE,2);
    add(0,0,0,0,2,IDLE,0);
`else
    first_cyc = 3'd1;
    // Normal run
    add(1,0,0,0,1,FILL,1);  add(0,0,0,0,2,FILL,1);  add(0,0,0,1,1,WASH,1);
    add(0,0,0,0,9,WASH,1);  add(0,0,0,0,1,DRAIN,1); add(0,0,0,0,3,DRAIN,1);
    add(0,0,0,0,1,FILL,2);  add(0,0,0,0,2,FILL,2);  add(0,0,0,1,1,WASH,2);
    add(0,0,0,0,5,WASH,2);  add(0,0,0,0,1,DRAIN,2); add(0,0,0,0,3,DRAIN,2);
    add(0,0,0,0,1,SPIN,2);  add(0,0,0,0,4,SPIN,2);  add(0,0,0,0,1,DONE,2);
    add(0,0,0,0,2,IDLE,0);
    // Door pause at WASH timer=4, resume for 10 WASH cycles total, then abort in DRAIN
    add(1,0,0,0,1,FILL,1);  add(0,0,0,0,2,FILL,1);  add(0,0,0,1,1,WASH,1);
    add(0,0,0,0,4,WASH,1);  add(0,1,0,0,1,PAUSE,1); add(0,1,0,0,2,PAUSE,1);
    add(1,1,0,0,1,PAUSE,1); add(0,0,0,0,1,PAUSE,1); add(1,0,0,0,1,WASH,1);
    add(0,0,0,0,4,WASH,1);  add(0,0,0,0,1,DRAIN,1); add(0,0,1,0,1,ADRAIN,1);
    add(0,0,0,0,3,ADRAIN,1); add(0,0,0,0,1,IDLE,0);
    // Fill timeout fault, start ignored, abort clears
    add(1,0,0,0,1,FILL,1);  add(0,0,0,0,7,FILL,1);  add(0,0,0,0,1,FAULT,1);
    add(1,0,0,1,2,FAULT,1); add(0,0,1,0,1,IDLE,0);  add(0,0,0,0,1,IDLE,0);
    // Water already full on rinse fill; abort (with door) in SPIN, abort held through ADRAIN
    add(1,0,0,0,1,FILL,1);  add(0,0,0,0,2,FILL,1);  add(0,0,0,1,1,WASH,1);
    add(0,0,0,0,9,WASH,1);  add(0,0,0,0,1,DRAIN,1); add(0,0,0,0,3,DRAIN,1);
    add(0,0,0,1,1,FILL,2);  add(0,0,0,1,1,WASH,2);  add(0,0,0,0,5,WASH,2);
    add(0,0,0,0,1,DRAIN,2); add(0,0,0,0,3,DRAIN,2); add(0,0,0,0,1,SPIN,2);
    add(0,0,0,0,2,SPIN,2);  add(0,1,1,0,1,ADRAIN,2); add(0,0,1,0,3,ADRAIN,2);
    add(0,0,1,0,1,IDLE,0);  add(0,0,0,0,1,IDLE,0);
    // Door on last SPIN cycle, resume exits at once; held start retriggers only after IDLE
    add(1,0,0,0,1,FILL,1);  add(0,0,0,0,2,FILL,1);  add(0,0,0,1,1,WASH,1);
    add(0,0,0,0,9,WASH,1);  add(0,0,0,0,1,DRAIN,1); add(0,0,0,0,3,DRAIN,1);
    add(0,0,0,0,1,FILL,2);  add(0,0,0,0,2,FILL,2);  add(0,0,0,1,1,WASH,2);
    add(0,0,0,0,5,WASH,2);  add(0,0,0,0,1,DRAIN,2); add(0,0,0,0,3,DRAIN,2);
    add(0,0,0,0,1,SPIN,2);  add(0,0,0,0,3,SPIN,2);  add(0,1,0,0,1,PAUSE,2);
    add(1,0,0,0,1,SPIN,2);  add(1,0,0,0,1,DONE,2);  add(1,0,0,0,1,IDLE,0);
    add(1,0,0,0,1,FILL,1);  add(0,0,1,0,1,ADRAIN,1); add(0,0,0,0,3,ADRAIN,1);
    add(0,0,0,0,1,IDLE,0);
`endif
    // Start with the door open is ignored
    add(1,1,0,0,2,IDLE,0);
    add(0,0,0,0,1,IDLE,0);

    foreach (table_q[i]) begin
      v = table_q[i];
      for (int r = 0; r < v.reps; r++) step(v);
    end

    // Asynchronous reset in the middle of a DRAIN
    start      = 1'b1;
    water_full = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (state != DRAIN && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL drain wait: got state=%0d after %0d cycles, expected state=%0d", state, n, DRAIN);
    end else begin
      check_now("pre-reset drain", '{DRAIN, first_cyc, decode(DRAIN)});
      #2;
      rst_n = 1'b0;
      #1;
      check_now("async reset", '{IDLE, 3'd0, 9'd0});
    end
    water_full = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    v = '{1'b0, 1'b0, 1'b0, 1'b0, 1, IDLE, 3'd0};
    step(v);
    v = '{1'b1, 1'b0, 1'b0, 1'b0, 1, FILL, first_cyc};
    step(v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
